// File: rtl/jtag_multi_chain_tap.sv
// Soft IEEE 1149.1 TAP with a generic IR and NUM_CHANNELS user DRs with parallel capture/update.
// Optional IDCODE register: define JTAG_IDCODE_EN.
module jtag_multi_chain_tap #(
    parameter int unsigned          IR_WIDTH     = 8,
    parameter int unsigned          DR_WIDTH     = 9,
    parameter int unsigned          NUM_CHANNELS = 4,
    parameter logic [IR_WIDTH-1:0]  CH_BASE      = IR_WIDTH'(8'h32),
    parameter logic [31:0]          IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                             TCK,
    input  logic                             JRSTN,
    input  logic                             TMS,
    input  logic                             TDI,
    output logic                             TDO,
    input  logic [NUM_CHANNELS*DR_WIDTH-1:0] dr_in,
    output logic [NUM_CHANNELS*DR_WIDTH-1:0] dr_out,
    output logic [NUM_CHANNELS-1:0]          dr_update_stb,
    output logic [IR_WIDTH-1:0]              ir_out,
    output logic [3:0]                       tap_state
);

    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IR_WIDTH-1:0] IR_ONES = '1;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IDCODE_OP  = IR_ONES - IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] DEFAULT_IR = IDCODE_OP;
`else
    localparam logic [IR_WIDTH-1:0] DEFAULT_IR = IR_ONES;
`endif

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PA_DR  = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PA_IR  = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_e;

    tap_state_e state_q, state_d;

    logic [IR_WIDTH-1:0]     ir_sr;
    logic [DR_WIDTH-1:0]     dr_sr;
    logic                    bypass_sr;
    logic                    ch_hit;
    logic [CH_W-1:0]         ch_idx;
    logic [DR_WIDTH-1:0]     cap_val;
    logic [NUM_CHANNELS-1:0] upd_onehot;

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_sr;
    logic        id_hit;
    assign id_hit = (ir_out == IDCODE_OP);
`else
    // IDCODE_VALUE has no consumer without the IDCODE register.
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;
`endif

    assign tap_state = state_q;

    always_ff @(posedge TCK or negedge JRSTN) begin
        if (!JRSTN) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PA_DR;
            PA_DR:  state_d = TMS ? EX2_DR : PA_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PA_IR;
            PA_IR:  state_d = TMS ? EX2_IR : PA_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Channel decode; a matching channel opcode takes priority over BYPASS/IDCODE.
    always_comb begin
        ch_hit  = 1'b0;
        ch_idx  = '0;
        cap_val = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (ir_out == CH_BASE + IR_WIDTH'(k)) begin
                ch_hit  = 1'b1;
                ch_idx  = CH_W'(k);
                cap_val = dr_in[k*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    always_comb begin
        upd_onehot = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (state_q == UPD_DR && ch_hit && ch_idx == CH_W'(k)) begin
                upd_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge TCK or negedge JRSTN) begin
        if (!JRSTN) begin
            ir_sr  <= '0;
            ir_out <= DEFAULT_IR;
        end else begin
            case (state_q)
                CAP_IR: ir_sr  <= IR_WIDTH'(1);
                SH_IR:  ir_sr  <= {TDI, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: ir_out <= ir_sr;
                default: ;
            endcase
            // Any entry into (or stay in) TLR restores the default instruction.
            if (state_d == TLR) begin
                ir_out <= DEFAULT_IR;
            end
        end
    end

    always_ff @(posedge TCK or negedge JRSTN) begin
        if (!JRSTN) begin
            dr_sr     <= '0;
            bypass_sr <= 1'b0;
`ifdef JTAG_IDCODE_EN
            id_sr     <= '0;
`endif
        end else begin
            case (state_q)
                CAP_DR: begin
                    dr_sr     <= cap_val;
                    bypass_sr <= 1'b0;
`ifdef JTAG_IDCODE_EN
                    id_sr     <= IDCODE_VALUE;
`endif
                end
                SH_DR: begin
                    dr_sr     <= (dr_sr >> 1) | (DR_WIDTH'(TDI) << (DR_WIDTH - 1));
                    bypass_sr <= TDI;
`ifdef JTAG_IDCODE_EN
                    id_sr     <= {TDI, id_sr[31:1]};
`endif
                end
                default: ;
            endcase
        end
    end

    // Only JRSTN clears the update registers; TLR via TMS leaves them alone.
    always_ff @(posedge TCK or negedge JRSTN) begin
        if (!JRSTN) begin
            dr_out        <= '0;
            dr_update_stb <= '0;
        end else begin
            dr_update_stb <= upd_onehot;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (upd_onehot[k]) begin
                    dr_out[k*DR_WIDTH +: DR_WIDTH] <= dr_sr;
                end
            end
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state_q == SH_IR) begin
            TDO = ir_sr[0];
        end else if (state_q == SH_DR) begin
            if (ch_hit) begin
                TDO = dr_sr[0];
`ifdef JTAG_IDCODE_EN
            end else if (id_hit) begin
                TDO = id_sr[0];
`endif
            end else begin
                TDO = bypass_sr;
            end
        end
    end

endmodule

// File: tb/tb_jtag_multi_chain_tap.sv
// Self-checking bench for jtag_multi_chain_tap: scan tasks drive TCK/TMS/TDI, TDO is scored from exp_q.
// Exercises the IDCODE path when JTAG_IDCODE_EN is defined.
module tb_jtag_multi_chain_tap;

    localparam int IRW = 8;
    localparam int DRW = 9;
    localparam int NCH = 2;
    localparam int TW  = 1;

`ifdef JTAG_IDCODE_EN
    localparam logic [IRW-1:0] DEF_IR = 8'hFE;
`else
    localparam logic [IRW-1:0] DEF_IR = 8'hFF;
`endif

    logic               TCK;
    logic               JRSTN;
    logic               TMS;
    logic               TDI;
    logic               TDO;
    logic [NCH*DRW-1:0] dr_in;
    logic [NCH*DRW-1:0] dr_out;
    logic [NCH-1:0]     dr_update_stb;
    logic [IRW-1:0]     ir_out;
    logic [3:0]         tap_state;

    int n_cmp;
    int n_err;
    logic [TW-1:0] exp_q[$];

    jtag_multi_chain_tap #(
        .IR_WIDTH     (IRW),
        .DR_WIDTH     (DRW),
        .NUM_CHANNELS (NCH),
        .CH_BASE      (8'h32),
        .IDCODE_VALUE (32'h1234_5678)
    ) dut (
        .TCK           (TCK),
        .JRSTN         (JRSTN),
        .TMS           (TMS),
        .TDI           (TDI),
        .TDO           (TDO),
        .dr_in         (dr_in),
        .dr_out        (dr_out),
        .dr_update_stb (dr_update_stb),
        .ir_out        (ir_out),
        .tap_state     (tap_state)
    );

    // Clock and reset
    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change at negedge, outputs observed 1ns after posedge.
    task automatic step(input logic tms, input logic tdi);
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic scan_bit(input logic tms, input logic tdi);
        logic [TW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (TDO !== e[0]) begin
                n_err++;
                $display("FAIL tdo_bit: got %0b expected %0b (state %0d)", TDO, e[0], tap_state);
            end
        end
        step(tms, tdi);
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(TW'(v[i]));
    endtask

    task automatic shift_ir(input logic [IRW-1:0] v);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < IRW; i++) scan_bit(i == IRW - 1, v[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input logic [31:0] v, input int n,
                            output logic [NCH-1:0] stb_upd, output logic [NCH-1:0] stb_next);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) scan_bit(i == n - 1, v[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        stb_upd = dr_update_stb;
        step(1'b0, 1'b0);
        stb_next = dr_update_stb;
    endtask

    task automatic test_reset();
        JRSTN = 1'b0;
        TMS   = 1'b1;
        TDI   = 1'b0;
        dr_in = '0;
        repeat (2) @(posedge TCK);
        #1;
        n_cmp++; if (tap_state !== 4'd0) begin n_err++; $display("FAIL rst_state: got %0d expected 0", tap_state); end
        n_cmp++; if (ir_out !== DEF_IR) begin n_err++; $display("FAIL rst_ir: got %h expected %h", ir_out, DEF_IR); end
        n_cmp++; if (dr_out !== '0) begin n_err++; $display("FAIL rst_dr_out: got %h expected 0", dr_out); end
        n_cmp++; if (dr_update_stb !== '0) begin n_err++; $display("FAIL rst_stb: got %b expected 0", dr_update_stb); end
        n_cmp++; if (TDO !== 1'b0) begin n_err++; $display("FAIL rst_tdo: got %b expected 0", TDO); end
        @(negedge TCK);
        JRSTN = 1'b1;
        step(1'b0, 1'b0);
        n_cmp++; if (tap_state !== 4'd1) begin n_err++; $display("FAIL rti_state: got %0d expected 1", tap_state); end
        n_cmp++; if (dr_out !== '0) begin n_err++; $display("FAIL rti_dr_out: got %h expected 0", dr_out); end
    endtask

    task automatic test_channel_write();
        logic [NCH-1:0] s1, s2;
        push_bits(32'h01, IRW);
        shift_ir(8'h32);
        n_cmp++; if (ir_out !== 8'h32) begin n_err++; $display("FAIL ir_ch0: got %h expected 32", ir_out); end
        shift_dr(32'b011001101, DRW, s1, s2);
        n_cmp++; if (dr_out[8:0] !== 9'h0CD) begin n_err++; $display("FAIL ch0_write: got %h expected 0cd", dr_out[8:0]); end
        n_cmp++; if (dr_out[17:9] !== 9'h000) begin n_err++; $display("FAIL ch1_untouched: got %h expected 000", dr_out[17:9]); end
        n_cmp++; if (s1 !== 2'b01) begin n_err++; $display("FAIL ch0_stb: got %b expected 01", s1); end
        n_cmp++; if (s2 !== 2'b00) begin n_err++; $display("FAIL ch0_stb_clear: got %b expected 00", s2); end
    endtask

    task automatic test_second_channel();
        logic [NCH-1:0] s1, s2;
        shift_ir(8'h33);
        n_cmp++; if (dr_out !== {9'h000, 9'h0CD}) begin n_err++; $display("FAIL ir_change_dr: got %h expected %h", dr_out, {9'h000, 9'h0CD}); end
        shift_dr(32'b001100000, DRW, s1, s2);
        n_cmp++; if (dr_out[17:9] !== 9'h060) begin n_err++; $display("FAIL ch1_write: got %h expected 060", dr_out[17:9]); end
        n_cmp++; if (dr_out[8:0] !== 9'h0CD) begin n_err++; $display("FAIL ch0_hold: got %h expected 0cd", dr_out[8:0]); end
        n_cmp++; if (s1 !== 2'b10) begin n_err++; $display("FAIL ch1_stb: got %b expected 10", s1); end
        n_cmp++; if (s2 !== 2'b00) begin n_err++; $display("FAIL ch1_stb_clear: got %b expected 00", s2); end
    endtask

    task automatic test_capture();
        logic [NCH-1:0] s1, s2;
        dr_in = {9'h0AA, 9'h155};
        shift_ir(8'h32);
        push_bits(32'h155, DRW);
        shift_dr(32'h0CD, DRW, s1, s2);
        n_cmp++; if (dr_out[8:0] !== 9'h0CD) begin n_err++; $display("FAIL cap_ch0_wr: got %h expected 0cd", dr_out[8:0]); end
        shift_ir(8'h33);
        push_bits(32'h0AA, DRW);
        shift_dr(32'h1F0, DRW, s1, s2);
        n_cmp++; if (dr_out !== {9'h1F0, 9'h0CD}) begin n_err++; $display("FAIL cap_ch1_wr: got %h expected %h", dr_out, {9'h1F0, 9'h0CD}); end
        n_cmp++; if (s1 !== 2'b10) begin n_err++; $display("FAIL cap_ch1_stb: got %b expected 10", s1); end
    endtask

    task automatic test_bypass();
        shift_ir(8'hFF);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        push_bits(32'b1010, 4);
        scan_bit(1'b0, 1'b1);
        scan_bit(1'b0, 1'b0);
        scan_bit(1'b0, 1'b1);
        scan_bit(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            if (i == 2) begin
                n_cmp++; if (dr_update_stb !== 2'b00) begin n_err++; $display("FAIL byp_stb: got %b expected 00", dr_update_stb); end
            end
        end
        n_cmp++; if (tap_state !== 4'd0) begin n_err++; $display("FAIL byp_tlr: got %0d expected 0", tap_state); end
        n_cmp++; if (dr_out !== {9'h1F0, 9'h0CD}) begin n_err++; $display("FAIL byp_dr_hold: got %h expected %h", dr_out, {9'h1F0, 9'h0CD}); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_tlr_default();
        shift_ir(8'h33);
        n_cmp++; if (ir_out !== 8'h33) begin n_err++; $display("FAIL tlr_pre_ir: got %h expected 33", ir_out); end
        repeat (5) step(1'b1, 1'b0);
        n_cmp++; if (tap_state !== 4'd0) begin n_err++; $display("FAIL tlr_state: got %0d expected 0", tap_state); end
        n_cmp++; if (ir_out !== DEF_IR) begin n_err++; $display("FAIL tlr_ir: got %h expected %h", ir_out, DEF_IR); end
        n_cmp++; if (dr_out !== {9'h1F0, 9'h0CD}) begin n_err++; $display("FAIL tlr_dr_hold: got %h expected %h", dr_out, {9'h1F0, 9'h0CD}); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [DRW-1:0] v1, v2;
        v1 = DRW'($urandom_range(0, 511));
        v2 = ~v1;
        shift_ir(8'h32);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < DRW; i++) scan_bit(i == DRW - 1, v1[i]);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_cmp++; if (dr_update_stb !== 2'b01) begin n_err++; $display("FAIL b2b_stb1: got %b expected 01", dr_update_stb); end
        n_cmp++; if (dr_out[8:0] !== v1) begin n_err++; $display("FAIL b2b_val1: got %h expected %h", dr_out[8:0], v1); end
        step(1'b0, 1'b0);
        n_cmp++; if (dr_update_stb !== 2'b00) begin n_err++; $display("FAIL b2b_gap: got %b expected 00", dr_update_stb); end
        step(1'b0, 1'b0);
        for (int i = 0; i < DRW; i++) scan_bit(i == DRW - 1, v2[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_cmp++; if (dr_update_stb !== 2'b01) begin n_err++; $display("FAIL b2b_stb2: got %b expected 01", dr_update_stb); end
        n_cmp++; if (dr_out !== {9'h1F0, v2}) begin n_err++; $display("FAIL b2b_val2: got %h expected %h", dr_out, {9'h1F0, v2}); end
        step(1'b0, 1'b0);
        n_cmp++; if (dr_update_stb !== 2'b00) begin n_err++; $display("FAIL b2b_end: got %b expected 00", dr_update_stb); end
    endtask

    task automatic test_reset_mid_shift();
        shift_ir(8'h32);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) scan_bit(1'b0, 1'b1);
        #2;
        JRSTN = 1'b0;
        #1;
        n_cmp++; if (tap_state !== 4'd0) begin n_err++; $display("FAIL mid_rst_state: got %0d expected 0", tap_state); end
        n_cmp++; if (dr_out !== '0) begin n_err++; $display("FAIL mid_rst_dr: got %h expected 0", dr_out); end
        n_cmp++; if (ir_out !== DEF_IR) begin n_err++; $display("FAIL mid_rst_ir: got %h expected %h", ir_out, DEF_IR); end
        repeat (2) @(posedge TCK);
        #1;
        n_cmp++; if (dr_update_stb !== 2'b00) begin n_err++; $display("FAIL mid_rst_stb: got %b expected 00", dr_update_stb); end
        @(negedge TCK);
        JRSTN = 1'b1;
        step(1'b0, 1'b0);
        n_cmp++; if (dr_out !== '0) begin n_err++; $display("FAIL post_rst_dr: got %h expected 0", dr_out); end
    endtask

`ifdef JTAG_IDCODE_EN
    task automatic test_idcode();
        logic [NCH-1:0] s1, s2;
        push_bits(32'h1234_5678, 32);
        shift_dr(32'h0, 32, s1, s2);
        n_cmp++; if (s1 !== 2'b00) begin n_err++; $display("FAIL id_stb: got %b expected 00", s1); end
        n_cmp++; if (dr_out !== '0) begin n_err++; $display("FAIL id_dr: got %h expected 0", dr_out); end
    endtask
`else
    task automatic test_unused_opcode();
        logic [NCH-1:0] s1, s2;
        shift_ir(8'hFE);
        push_bits(32'b1100, 4);
        shift_dr(32'b0110, 4, s1, s2);
        n_cmp++; if (s1 !== 2'b00) begin n_err++; $display("FAIL fe_stb: got %b expected 00", s1); end
        n_cmp++; if (dr_out !== '0) begin n_err++; $display("FAIL fe_dr: got %h expected 0", dr_out); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_channel_write();
        test_second_channel();
        test_capture();
        test_bypass();
        test_tlr_default();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef JTAG_IDCODE_EN
        test_idcode();
`else
        test_unused_opcode();
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL exp_q_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
